nebula_switch_allocator: RTL and testbench

NEBULA_SWITCH_ALLOCATOR -- requirements
Module: nebula_switch_allocator

---
 rtl/nebula_switch_allocator_pkg.sv | 42 ++++
 rtl/nebula_switch_allocator_rr_arbiter.sv | 39 +++
 rtl/nebula_switch_allocator.sv | 197 +++++++++++++++++++
 tb/tb_nebula_switch_allocator.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nebula_switch_allocator_pkg.sv
// -----------------------------------------------------------------------------
// nebula_pkg
// Shared router definitions: port count and port indices, performance counter
// width, flit type encoding, switch allocator FSM states and the round-robin
// pointer advance helper.
// -----------------------------------------------------------------------------
package nebula_pkg;

    localparam int NUM_PORTS          = 5;
    localparam int PORT_N             = 0;
    localparam int PORT_E             = 1;
    localparam int PORT_S             = 2;
    localparam int PORT_W             = 3;
    localparam int PORT_LOCAL         = 4;
    localparam int PORT_IDX_W         = 3;
    localparam int PERF_COUNTER_WIDTH = 16;

    typedef enum logic [1:0] {
        FLIT_HEAD   = 2'd0,
        FLIT_BODY   = 2'd1,
        FLIT_TAIL   = 2'd2,
        FLIT_SINGLE = 2'd3
    } flit_type_e;

    typedef enum logic {
        SA_IDLE   = 1'b0,
        SA_LOCKED = 1'b1
    } sa_state_e;

    // Round-robin pointer that follows a given winner, wrapping at n.
    function automatic logic [PORT_IDX_W-1:0] rr_next(input logic [PORT_IDX_W-1:0] idx,
                                                       input int unsigned n);
        logic [PORT_IDX_W-1:0] nxt;
        if ((32'(idx) + 32'd1) >= n) begin
            nxt = 3'd0;
        end else begin
            nxt = idx + 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/nebula_switch_allocator_rr_arbiter.sv
// -----------------------------------------------------------------------------
// nebula_rr_arbiter
// Round-robin arbiter: grants the first requester at or after ptr, wrapping
// N-1 -> 0. Purely combinational.
// Ports:
//   req   [N-1:0]  request vector
//   ptr   [2:0]    highest-priority index this cycle
//   grant [N-1:0]  one-hot grant (all zero when no request)
// -----------------------------------------------------------------------------
module nebula_rr_arbiter
    import nebula_pkg::*;
#(
    parameter int N = 5
) (
    input  logic [N-1:0]            req,
    input  logic [PORT_IDX_W-1:0]   ptr,
    output logic [N-1:0]            grant
);

    int   idx_s;
    logic found_s;

    // Rotating priority scan starting at ptr.
    always_comb begin
        grant   = '0;
        found_s = 1'b0;
        idx_s   = 0;
        for (int k = 0; k < N; k++) begin
            idx_s = (int'(ptr) + k) % N;
            if (!found_s && req[idx_s]) begin
                grant[idx_s] = 1'b1;
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/nebula_switch_allocator.sv
// -----------------------------------------------------------------------------
// nebula_switch_allocator
// Per-output wormhole switch allocator. Each output runs an IDLE/LOCKED FSM:
// in IDLE a round-robin arbiter picks among head flits aimed at the output and
// grants in the same cycle; a transferred multi-flit head locks the output to
// its input until the tail transfers.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid/port/head/tail  per-input request at VC buffer head
//   out_ready           per-output downstream acceptance
//   in_grant            per-input dequeue strobe (combinational)
//   out_sel/out_valid   per-output crossbar select and flit-valid
//   locked              per-output packet lock
//   stall_err           sticky: a locked output starved for STALL_LIMIT cycles
//   bad_port_err        sticky: a request named a nonexistent output
//   grant_count         completed packets (tail transfers), wrapping
// -----------------------------------------------------------------------------
module nebula_switch_allocator
    import nebula_pkg::*;
#(
    parameter int NUM_PORTS   = nebula_pkg::NUM_PORTS,
    parameter int STALL_LIMIT = 64
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_PORTS-1:0]                   req_valid,
    input  logic [NUM_PORTS-1:0][PORT_IDX_W-1:0]   req_port,
    input  logic [NUM_PORTS-1:0]                   req_head,
    input  logic [NUM_PORTS-1:0]                   req_tail,
    input  logic [NUM_PORTS-1:0]                   out_ready,
    output logic [NUM_PORTS-1:0]                   in_grant,
    output logic [NUM_PORTS-1:0][PORT_IDX_W-1:0]   out_sel,
    output logic [NUM_PORTS-1:0]                   out_valid,
    output logic [NUM_PORTS-1:0]                   locked,
    output logic                                   stall_err,
    output logic                                   bad_port_err,
    output logic [PERF_COUNTER_WIDTH-1:0]          grant_count
);

    localparam int STALL_W = $clog2(STALL_LIMIT + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);

    sa_state_e                       state_r      [NUM_PORTS];
    sa_state_e                       state_nxt_s  [NUM_PORTS];
    logic [PORT_IDX_W-1:0]           owner_r      [NUM_PORTS];
    logic [PORT_IDX_W-1:0]           owner_nxt_s  [NUM_PORTS];
    logic [PORT_IDX_W-1:0]           rr_ptr_r     [NUM_PORTS];
    logic [PORT_IDX_W-1:0]           rr_ptr_nxt_s [NUM_PORTS];
    logic [STALL_W-1:0]              stall_cnt_r  [NUM_PORTS];
    logic [STALL_W-1:0]              stall_cnt_nxt_s [NUM_PORTS];

    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] cand_s;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] arb_gnt_s;
    logic [NUM_PORTS-1:0]            xfer_s;
    logic [NUM_PORTS-1:0]            tail_done_s;
    logic [PERF_COUNTER_WIDTH-1:0]   tail_cnt_s;
    logic                            stall_err_nxt_s;
    logic                            bad_port_nxt_s;

    // Head-flit candidates per output; out-of-range ports never match.
    always_comb begin
        cand_s = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                cand_s[o][i] = req_valid[i] & req_head[i] & (req_port[i] == PORT_IDX_W'(o));
            end
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_arb
        nebula_rr_arbiter #(
            .N (NUM_PORTS)
        ) u_arb (
            .req   (cand_s[g]),
            .ptr   (rr_ptr_r[g]),
            .grant (arb_gnt_s[g])
        );
    end

    // Crossbar select, output valid, transfer and dequeue strobes.
    always_comb begin
        out_valid   = '0;
        out_sel     = '0;
        locked      = '0;
        in_grant    = '0;
        xfer_s      = '0;
        tail_done_s = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (rst_n) begin
                case (state_r[o])
                    SA_IDLE: begin
                        out_valid[o] = |arb_gnt_s[o];
                        // Grant is one-hot, so OR-ing masked indices encodes it.
                        for (int i = 0; i < NUM_PORTS; i++) begin
                            out_sel[o] = out_sel[o] | ({PORT_IDX_W{arb_gnt_s[o][i]}} & PORT_IDX_W'(i));
                        end
                    end
                    SA_LOCKED: begin
                        locked[o]    = 1'b1;
                        out_sel[o]   = owner_r[o];
                        // A head from the owner means a new packet, not a continuation.
                        out_valid[o] = req_valid[owner_r[o]]
                                     & (req_port[owner_r[o]] == PORT_IDX_W'(o))
                                     & ~req_head[owner_r[o]];
                    end
                    default: begin
                        out_valid[o] = 1'b0;
                    end
                endcase
            end else begin
                // Held in reset: everything stays at its zero default.
                out_valid[o] = 1'b0;
            end
            xfer_s[o]      = out_valid[o] & out_ready[o];
            tail_done_s[o] = xfer_s[o] & req_tail[out_sel[o]];
            for (int i = 0; i < NUM_PORTS; i++) begin
                in_grant[i] = in_grant[i] | (xfer_s[o] & (out_sel[o] == PORT_IDX_W'(i)));
            end
        end
    end

    // Next-state for per-output FSMs, pointers, stall counters and flags.
    always_comb begin
        tail_cnt_s      = '0;
        stall_err_nxt_s = stall_err;
        bad_port_nxt_s  = bad_port_err;
        for (int o = 0; o < NUM_PORTS; o++) begin
            state_nxt_s[o]     = state_r[o];
            owner_nxt_s[o]     = owner_r[o];
            rr_ptr_nxt_s[o]    = rr_ptr_r[o];
            stall_cnt_nxt_s[o] = '0;
            case (state_r[o])
                SA_IDLE: begin
                    if (xfer_s[o]) begin
                        rr_ptr_nxt_s[o] = rr_next(out_sel[o], NUM_PORTS);
                        if (req_tail[out_sel[o]]) begin
                            state_nxt_s[o] = SA_IDLE;
                        end else begin
                            state_nxt_s[o] = SA_LOCKED;
                            owner_nxt_s[o] = out_sel[o];
                        end
                    end else begin
                        state_nxt_s[o] = SA_IDLE;
                    end
                end
                SA_LOCKED: begin
                    if (xfer_s[o]) begin
                        if (req_tail[owner_r[o]]) begin
                            state_nxt_s[o] = SA_IDLE;
                        end else begin
                            state_nxt_s[o] = SA_LOCKED;
                        end
                    end else if (stall_cnt_r[o] != STALL_MAX) begin
                        stall_cnt_nxt_s[o] = stall_cnt_r[o] + {{(STALL_W-1){1'b0}}, 1'b1};
                    end else begin
                        stall_cnt_nxt_s[o] = stall_cnt_r[o];
                    end
                end
                default: begin
                    state_nxt_s[o] = SA_IDLE;
                end
            endcase
            stall_err_nxt_s = stall_err_nxt_s | (stall_cnt_nxt_s[o] == STALL_MAX);
            tail_cnt_s      = tail_cnt_s + PERF_COUNTER_WIDTH'(tail_done_s[o]);
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            bad_port_nxt_s = bad_port_nxt_s
                           | (req_valid[i] & (req_port[i] >= PORT_IDX_W'(NUM_PORTS)));
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                state_r[o]     <= SA_IDLE;
                owner_r[o]     <= '0;
                rr_ptr_r[o]    <= '0;
                stall_cnt_r[o] <= '0;
            end
            stall_err    <= 1'b0;
            bad_port_err <= 1'b0;
            grant_count  <= '0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                state_r[o]     <= state_nxt_s[o];
                owner_r[o]     <= owner_nxt_s[o];
                rr_ptr_r[o]    <= rr_ptr_nxt_s[o];
                stall_cnt_r[o] <= stall_cnt_nxt_s[o];
            end
            stall_err    <= stall_err_nxt_s;
            bad_port_err <= bad_port_nxt_s;
            grant_count  <= grant_count + tail_cnt_s;
        end
    end

endmodule

// File: tb/tb_nebula_switch_allocator.sv
// -----------------------------------------------------------------------------
// tb_nebula_switch_allocator
// Directed scenarios followed by randomized traffic, all compared against a
// packet-level reference model of the allocator's arbitration and locking rules.
// -----------------------------------------------------------------------------
module tb_nebula_switch_allocator;

    localparam int NP    = 5;
    localparam int LIMIT = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic [NP-1:0]        req_valid;
    logic [NP-1:0][2:0]   req_port;
    logic [NP-1:0]        req_head;
    logic [NP-1:0]        req_tail;
    logic [NP-1:0]        out_ready;
    logic [NP-1:0]        in_grant;
    logic [NP-1:0][2:0]   out_sel;
    logic [NP-1:0]        out_valid;
    logic [NP-1:0]        locked;
    logic                 stall_err;
    logic                 bad_port_err;
    logic [15:0]          grant_count;

    nebula_switch_allocator #(
        .NUM_PORTS   (NP),
        .STALL_LIMIT (LIMIT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_port     (req_port),
        .req_head     (req_head),
        .req_tail     (req_tail),
        .out_ready    (out_ready),
        .in_grant     (in_grant),
        .out_sel      (out_sel),
        .out_valid    (out_valid),
        .locked       (locked),
        .stall_err    (stall_err),
        .bad_port_err (bad_port_err),
        .grant_count  (grant_count)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: owner of each output (-1 = free), round-robin start,
    // starvation counter, sticky flags and packet count.
    int m_owner [NP];
    int m_rr    [NP];
    int m_stall [NP];
    bit m_stall_err;
    bit m_bad;
    int m_count;
    bit e_valid [NP];
    int e_sel   [NP];
    bit e_xfer  [NP];

    logic [NP-1:0]      last_grant;
    logic [NP-1:0][2:0] last_sel;
    logic [NP-1:0]      last_locked;
    logic               last_stall_err;
    logic               last_bad;
    logic [15:0]        last_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int o = 0; o < NP; o++) begin
            m_owner[o] = -1;
            m_rr[o]    = 0;
            m_stall[o] = 0;
        end
        m_stall_err = 1'b0;
        m_bad       = 1'b0;
        m_count     = 0;
    endfunction

    // Who is presented on each output this cycle.
    function automatic void model_comb();
        for (int o = 0; o < NP; o++) begin
            e_valid[o] = 1'b0;
            e_sel[o]   = 0;
            e_xfer[o]  = 1'b0;
            if (rst_n === 1'b1) begin
                if (m_owner[o] < 0) begin
                    for (int k = NP - 1; k >= 0; k--) begin
                        int i;
                        i = (m_rr[o] + k) % NP;
                        if (req_valid[i] && req_head[i] && int'(req_port[i]) == o) begin
                            e_valid[o] = 1'b1;
                            e_sel[o]   = i;
                        end
                    end
                end else begin
                    e_sel[o]   = m_owner[o];
                    e_valid[o] = req_valid[m_owner[o]] && !req_head[m_owner[o]]
                                 && int'(req_port[m_owner[o]]) == o;
                end
                e_xfer[o] = e_valid[o] && out_ready[o];
            end
        end
    endfunction

    // Advance the model across one rising edge.
    function automatic void model_seq();
        if (rst_n !== 1'b1) begin
            model_reset();
        end else begin
            for (int i = 0; i < NP; i++) begin
                if (req_valid[i] && int'(req_port[i]) >= NP) m_bad = 1'b1;
            end
            for (int o = 0; o < NP; o++) begin
                if (e_xfer[o]) begin
                    m_stall[o] = 0;
                    if (m_owner[o] < 0) begin
                        m_rr[o] = (e_sel[o] + 1) % NP;
                        if (req_tail[e_sel[o]]) m_count++;
                        else m_owner[o] = e_sel[o];
                    end else if (req_tail[m_owner[o]]) begin
                        m_owner[o] = -1;
                        m_count++;
                    end
                end else if (m_owner[o] >= 0) begin
                    if (m_stall[o] < LIMIT) m_stall[o]++;
                    if (m_stall[o] == LIMIT) m_stall_err = 1'b1;
                end else begin
                    m_stall[o] = 0;
                end
            end
            m_count = m_count % 65536;
        end
    endfunction

    // One clock cycle: check combinational outputs, clock, check registers.
    task automatic step();
        logic [NP-1:0] exp_grant;
        #1;
        model_comb();
        exp_grant = '0;
        for (int o = 0; o < NP; o++) begin
            bit exp_lock;
            exp_lock = (rst_n === 1'b1) && (m_owner[o] >= 0);
            chk($sformatf("out_valid[%0d]", o), 32'(out_valid[o]), 32'(e_valid[o]));
            chk($sformatf("locked[%0d]", o), 32'(locked[o]), 32'(exp_lock));
            if (e_valid[o] || exp_lock || rst_n !== 1'b1)
                chk($sformatf("out_sel[%0d]", o), 32'(out_sel[o]), 32'(e_sel[o]));
            if (e_xfer[o]) exp_grant[e_sel[o]] = 1'b1;
        end
        chk("in_grant", 32'(in_grant), 32'(exp_grant));
        last_grant  = in_grant;
        last_sel    = out_sel;
        last_locked = locked;
        @(posedge clk);
        model_seq();
        #1;
        chk("grant_count", 32'(grant_count), 32'(m_count));
        chk("stall_err", 32'(stall_err), 32'(m_stall_err));
        chk("bad_port_err", 32'(bad_port_err), 32'(m_bad));
        last_stall_err = stall_err;
        last_bad       = bad_port_err;
        last_count     = grant_count;
        @(negedge clk);
    endtask

    task automatic set_idle();
        req_valid = '0;
        req_port  = '0;
        req_head  = '0;
        req_tail  = '0;
        out_ready = '1;
    endtask

    task automatic drive(input int i, input int port, input bit head, input bit tail);
        req_valid[i] = 1'b1;
        req_port[i]  = 3'(port);
        req_head[i]  = head;
        req_tail[i]  = tail;
    endtask

    initial begin
        model_reset();
        set_idle();
        rst_n = 1'b0;
        // Reset with live requests: outputs must stay quiet.
        drive(4, 4, 1'b1, 1'b1);
        drive(0, 1, 1'b1, 1'b0);
        step();
        step();
        chk("rst_grant", 32'(last_grant), 32'h0);
        chk("rst_count", 32'(last_count), 32'h0);

        // LOCAL SINGLE to LOCAL: same-cycle grant, one packet counted.
        rst_n = 1'b1;
        set_idle();
        drive(4, 4, 1'b1, 1'b1);
        step();
        chk("local_sel", 32'(last_sel[4]), 32'd4);
        chk("local_grant", 32'(last_grant), 32'h10);
        chk("local_count", 32'(last_count), 32'd1);

        // N, E, S SINGLEs to EAST: round-robin 0,1,2,0.
        set_idle();
        drive(0, 1, 1'b1, 1'b1);
        drive(1, 1, 1'b1, 1'b1);
        drive(2, 1, 1'b1, 1'b1);
        for (int c = 0; c < 4; c++) begin
            int exp_i;
            exp_i = c % 3;
            step();
            chk("rr_grant", 32'(last_grant), 32'(1 << exp_i));
        end

        // W 3-flit packet to EAST vs N head: W x3, then N.
        set_idle();
        drive(0, 1, 1'b1, 1'b1);
        drive(3, 1, 1'b1, 1'b0);
        step();
        chk("pkt_head", 32'(last_sel[1]), 32'd3);
        drive(3, 1, 1'b0, 1'b0);
        step();
        chk("pkt_body", 32'(last_sel[1]), 32'd3);
        drive(3, 1, 1'b0, 1'b1);
        step();
        chk("pkt_tail", 32'(last_grant), 32'h08);
        req_valid[3] = 1'b0;
        step();
        chk("pkt_next", 32'(last_grant), 32'h01);

        // LOCAL locks NORTH, then starves for LIMIT cycles.
        set_idle();
        drive(4, 0, 1'b1, 1'b0);
        step();
        drive(4, 0, 1'b0, 1'b0);
        out_ready[0] = 1'b0;
        for (int c = 1; c <= LIMIT; c++) begin
            step();
            if (c == LIMIT - 1) chk("stall_pre", 32'(last_stall_err), 32'd0);
        end
        chk("stall_set", 32'(last_stall_err), 32'd1);
        chk("stall_nogrant", 32'(last_grant), 32'h0);
        chk("stall_lock", 32'(last_locked[0]), 32'd1);
        out_ready[0] = 1'b1;
        step();
        chk("stall_body", 32'(last_grant), 32'h10);
        drive(4, 0, 1'b0, 1'b1);
        step();
        chk("stall_tail", 32'(last_grant), 32'h10);

        // Nonexistent output port.
        set_idle();
        drive(2, 7, 1'b1, 1'b1);
        step();
        chk("bad_nogrant", 32'(last_grant), 32'h0);
        chk("bad_flag", 32'(last_bad), 32'd1);
        rst_n = 1'b0;
        step();
        chk("bad_clear", 32'(last_bad), 32'd0);

        // Reset mid-packet drops the lock.
        rst_n = 1'b1;
        set_idle();
        drive(0, 2, 1'b1, 1'b0);
        step();
        drive(0, 2, 1'b0, 1'b0);
        out_ready[2] = 1'b0;
        step();
        chk("mid_locked", 32'(last_locked[2]), 32'd1);
        rst_n = 1'b0;
        step();
        chk("mid_rst_lock", 32'(last_locked), 32'h0);
        rst_n = 1'b1;
        set_idle();
        drive(1, 2, 1'b1, 1'b1);
        step();
        chk("mid_new_sel", 32'(last_sel[2]), 32'd1);
        chk("mid_new_grant", 32'(last_grant), 32'h02);

        // Randomized traffic, including bad ports and occasional resets.
        for (int c = 0; c < 600; c++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            for (int i = 0; i < NP; i++) begin
                req_valid[i] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 29) == 0) req_port[i] = 3'($urandom_range(5, 7));
                else req_port[i] = 3'($urandom_range(0, NP - 1));
                req_head[i]  = ($urandom_range(0, 2) == 0);
                req_tail[i]  = ($urandom_range(0, 2) == 0);
                out_ready[i] = ($urandom_range(0, 3) != 0);
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
